// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the receive flag record.
// The state encoding matches the TX FSM so both sides read the same in waveforms.
package uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_flags_t;

    // 1 when the received parity bit disagrees with the data word.
    function automatic logic parity_error(input logic parity_bit, input logic word_xor,
                                          input logic odd);
        return parity_bit ^ word_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clock domain.
// Both flops reset to the idle line level so reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rx_serial,
    output logic rx_s
);

    logic meta;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= IDLE_LVL;
            rx_s <= IDLE_LVL;
        end else begin
            meta <= rx_serial;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_controlpath.sv
// UART receiver: oversampled start detection, mid-bit sampling of data/parity/stop,
// one-cycle data_valid with parity and framing flags held until the next word.
module uart_rx_controlpath
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    logic                 rx_s;

    logic [STATE_W-1:0]   state, state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 armed, armed_n;
    logic                 deliver;
    logic                 mid_half, mid_full;
    rx_flags_t            flags;

    uart_rx_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_s      (rx_s)
    );

    assign mid_half = (tick_cnt == HALF_LAST);
    assign mid_full = (tick_cnt == FULL_LAST);

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        perr_n  = perr;
        armed_n = armed;
        deliver = 1'b0;

        if (sample_tick) begin
            if (rx_s == IDLE_LVL) begin
                armed_n = 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (armed && rx_s == START_LVL) begin
                        state_n = ST_START;
                        tick_n  = '0;
                    end
                end

                ST_START: begin
                    if (mid_half) begin
                        if (rx_s == START_LVL) begin
                            state_n = ST_DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (mid_full) begin
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        tick_n  = '0;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = HAS_PAR ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (mid_full) begin
                        perr_n  = parity_error(rx_s, ^shreg, ODD_BIT);
                        state_n = ST_STOP;
                        tick_n  = '0;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    // Leave at mid-stop so a start bit right after a single stop bit is caught;
                    // a low stop bit disarms start detection until the line returns high.
                    if (mid_full) begin
                        deliver = 1'b1;
                        armed_n = rx_s;
                        state_n = ST_IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end

                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            armed    <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            perr     <= perr_n;
            armed    <= armed_n;
        end
    end

    // The stop-bit level is still on rx_s in the delivery cycle, so it feeds frame_err directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            flags      <= '0;
        end else begin
            data_valid <= deliver;
            if (deliver) begin
                data_out         <= shreg;
                flags.frame_err  <= (rx_s != STOP_LVL);
                flags.parity_err <= HAS_PAR && perr;
            end
        end
    end

    assign parity_err = flags.parity_err;
    assign frame_err  = flags.frame_err;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_controlpath.sv
// Self-checking bench: serial frames are driven bit by bit and a frame-level scoreboard
// predicts when each word appears, what the flags are, and when the receiver is busy.
module tb_uart_rx_controlpath;

    localparam int OS  = 16;
    localparam int DB  = 8;
    // Start edge to data_valid: 2 sync clocks, detect tick, start/data/parity bits, half stop bit.
    localparam int LAT = 2 + 1 + (1 + DB + 1) * OS + OS / 2;
    // Start edge to the end of a rejected glitch: 2 sync clocks, detect tick, half bit.
    localparam int GLITCH_END = 2 + 1 + OS / 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b1;
    logic          rx_serial = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    uart_rx_controlpath #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx_serial   (rx_serial),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int      start;
        int      done;
        bit      delivers;
        logic [DB-1:0] data;
        bit      perr;
        bit      ferr;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_valid = 0;
    int            n_busy = 0;
    int            last_start = 0;
    logic [DB-1:0] hold_data = '0;
    bit            hold_perr = 1'b0;
    bit            hold_ferr = 1'b0;
    bit            exp_valid;
    bit            exp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Per-cycle comparison against the frame scoreboard.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            sb.delete();
            hold_data = '0;
            hold_perr = 1'b0;
            hold_ferr = 1'b0;
            check("reset data_valid", data_valid, 0);
            check("reset busy", busy, 0);
            check("reset data_out", data_out, 0);
            check("reset parity_err", parity_err, 0);
            check("reset frame_err", frame_err, 0);
        end else begin
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            if (sb.size() > 0) begin
                if (cyc >= sb[0].start + 3 && cyc < sb[0].done) exp_busy = 1'b1;
                if (cyc >= sb[0].done) begin
                    if (sb[0].delivers) begin
                        exp_valid = 1'b1;
                        hold_data = sb[0].data;
                        hold_perr = sb[0].perr;
                        hold_ferr = sb[0].ferr;
                    end
                    void'(sb.pop_front());
                end
            end
            if (data_valid) n_valid++;
            if (busy) n_busy++;
            check("cycle data_valid", data_valid, exp_valid);
            check("cycle busy", busy, exp_busy);
            check("cycle data_out", data_out, hold_data);
            check("cycle parity_err", parity_err, hold_perr);
            check("cycle frame_err", frame_err, hold_ferr);
        end
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic idle(input int n);
        rx_serial = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input int start, input int done, input bit delivers,
                            input logic [DB-1:0] d, input bit perr, input bit ferr);
        exp_t e;
        e.start    = start;
        e.done     = done;
        e.delivers = delivers;
        e.data     = d;
        e.perr     = perr;
        e.ferr     = ferr;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                              input int gap_bits);
        logic [DB+2:0] f;
        logic          p;
        p = ^d;
        if (bad_par) p = ~p;
        f = {~bad_stop, p, d, 1'b0};
        last_start = cyc;
        push_exp(cyc, cyc + LAT, 1'b1, d, bad_par, bad_stop);
        for (int k = 0; k < DB + 3; k++) begin
            rx_serial = f[k];
            repeat (OS) @(posedge clock);
            #1;
        end
        idle(gap_bits * OS);
    endtask

    task automatic wait_valid(input int limit, output int at, output bit ok,
                              output logic [DB-1:0] d, output logic pe, output logic fe);
        ok = 1'b0;
        at = 0;
        d  = '0;
        pe = 1'b0;
        fe = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (data_valid) begin
                ok = 1'b1;
                at = cyc;
                d  = data_out;
                pe = parity_err;
                fe = frame_err;
                break;
            end
        end
    endtask

    int            at, at2, v0, b0;
    bit            ok, ok2;
    logic [DB-1:0] got, got2;
    logic          pe, fe, pe2, fe2;
    logic [DB-1:0] rd;
    bit            rbp, rbs;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(OS);

        // Clean 0xA5: delivery time pinned to the hand-computed 171 clocks.
        v0 = n_valid;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1);
            wait_valid(400, at, ok, got, pe, fe);
        join
        check("A5 delivered", ok, 1);
        check("A5 latency", at - last_start, 171);
        check("A5 data", got, 8'hA5);
        check("A5 parity_err", pe, 0);
        check("A5 frame_err", fe, 0);
        check("A5 single pulse", n_valid - v0, 1);
        check("A5 busy after", busy, 0);

        // 0x37 has odd weight, so a 0 parity bit is wrong under even parity.
        fork
            send_frame(8'h37, 1'b1, 1'b0, 1);
            wait_valid(400, at, ok, got, pe, fe);
        join
        check("37 delivered", ok, 1);
        check("37 data", got, 8'h37);
        check("37 parity_err", pe, 1);
        check("37 frame_err", fe, 0);

        fork
            send_frame(8'h5A, 1'b0, 1'b1, 1);
            wait_valid(400, at, ok, got, pe, fe);
        join
        check("5A delivered", ok, 1);
        check("5A data", got, 8'h5A);
        check("5A frame_err", fe, 1);
        check("5A parity_err", pe, 0);

        fork
            send_frame(8'h01, 1'b0, 1'b0, 1);
            wait_valid(400, at, ok, got, pe, fe);
        join
        check("01 data", got, 8'h01);
        check("01 frame_err", fe, 0);

        // 4-clock low glitch: start is rejected at the half-bit check.
        v0 = n_valid;
        b0 = n_busy;
        push_exp(cyc, cyc + GLITCH_END, 1'b0, '0, 1'b0, 1'b0);
        rx_serial = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        idle(3 * OS);
        check("glitch busy bounded", (n_busy - b0 > 0) && (n_busy - b0 <= 8), 1);
        check("glitch no valid", n_valid - v0, 0);
        check("glitch idle", busy, 0);

        // Break: line low for 20 bit times gives one all-zero word with a framing error.
        v0 = n_valid;
        push_exp(cyc, cyc + LAT, 1'b1, '0, 1'b0, 1'b1);
        rx_serial = 1'b0;
        repeat (20 * OS) @(posedge clock);
        #1;
        check("break one valid", n_valid - v0, 1);
        check("break data", data_out, 0);
        check("break frame_err", frame_err, 1);
        check("break not retriggered", busy, 0);
        idle(2 * OS);
        check("break recovered quiet", n_valid - v0, 1);

        // Back-to-back frames with a single stop bit.
        fork
            begin
                send_frame(8'hFF, 1'b0, 1'b0, 0);
                send_frame(8'h00, 1'b0, 1'b0, 1);
            end
            begin
                wait_valid(400, at, ok, got, pe, fe);
                wait_valid(400, at2, ok2, got2, pe2, fe2);
            end
        join
        check("b2b first delivered", ok, 1);
        check("b2b first data", got, 8'hFF);
        check("b2b second delivered", ok2, 1);
        check("b2b second data", got2, 8'h00);
        check("b2b spacing", at2 - at, 11 * OS);
        check("b2b flags", {pe, fe, pe2, fe2}, 0);

        // Randomised frames; the scoreboard checks every cycle.
        v0 = n_valid;
        for (int i = 0; i < 40; i++) begin
            rd  = DB'($urandom_range(0, 255));
            rbp = ($urandom_range(0, 3) == 0);
            rbs = ($urandom_range(0, 5) == 0);
            send_frame(rd, rbp, rbs, rbs ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2)));
        end
        idle(OS);
        check("random valid count", n_valid - v0, 40);

        // Reset in the middle of the data bits of a 0x0A-looking frame.
        v0 = n_valid;
        push_exp(cyc, cyc + LAT, 1'b1, 8'h0A, 1'b0, 1'b0);
        rx_serial = 1'b0;
        repeat (OS) @(posedge clock);
        #1;
        rx_serial = 1'b0;
        repeat (OS) @(posedge clock);
        #1;
        rx_serial = 1'b1;
        repeat (OS) @(posedge clock);
        #1;
        rx_serial = 1'b0;
        repeat (OS + 8) @(posedge clock);
        #1;
        check("pre-reset busy", busy, 1);
        reset = 1'b1;
        rx_serial = 1'b1;
        #1;
        check("mid-reset data_out", data_out, 0);
        check("mid-reset flags", {parity_err, frame_err}, 0);
        check("mid-reset busy", busy, 0);
        check("mid-reset valid", data_valid, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(OS);
        check("reset no valid", n_valid - v0, 0);

        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1);
            wait_valid(400, at, ok, got, pe, fe);
        join
        check("C3 delivered", ok, 1);
        check("C3 data", got, 8'hC3);
        check("C3 flags", {pe, fe}, 0);
        check("C3 latency", at - last_start, 171);

        idle(2 * OS);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
